oled_refresh_ctrl: RTL

Sequences the SSD1306 128x32 OLED over the shared I2C byte master. After reset it sends the init command table once. On each frame request it sets the address window and streams the 512-byte pixel buffer from the pet FSM's frame buffer. It handles NACK retry and coalesces refresh requests that arrive while a frame is in flight.

---
 rtl/oled_pkg.sv | 37 +++
 rtl/oled_cmd_rom.sv | 48 ++++
 rtl/oled_refresh_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 refresh controller.
package oled_pkg;

  typedef enum logic [2:0] {
    ST_INIT_PEND  = 3'd0,
    ST_IDLE       = 3'd1,
    ST_INIT_TX    = 3'd2,
    ST_WIN_TX     = 3'd3,
    ST_DATA_HDR   = 3'd4,
    ST_DATA_FETCH = 3'd5,
    ST_DATA_TX    = 3'd6,
    ST_BACKOFF    = 3'd7
  } state_t;

  localparam int INIT_LEN = 25;
  localparam int WIN_LEN  = 6;

  // Window bytes sit directly behind the init table in the command ROM.
  localparam logic [4:0] WIN_BASE = 5'd25;

  // Byte positions inside a command transaction: 0 = address, 1 = control, 2.. = ROM.
  localparam logic [4:0] INIT_LAST_POS = 5'd26;
  localparam logic [4:0] WIN_LAST_POS  = 5'd7;
  localparam logic [4:0] HDR_LAST_POS  = 5'd1;

  localparam logic [7:0] DISPLAY_OFF = 8'hAE;
  localparam logic [7:0] SET_COL     = 8'h21;
  localparam logic [7:0] SET_PAGE    = 8'h22;
  localparam logic [7:0] CTRL_CMD    = 8'h00;
  localparam logic [7:0] CTRL_DATA   = 8'h40;

  // Saturating 8-bit increment used by the NACK counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : (v + 8'd1);
  endfunction

endpackage

// File: rtl/oled_cmd_rom.sv
// Command byte lookup: SSD1306 init table (0..24) followed by the address window (25..30).
module oled_cmd_rom
  import oled_pkg::*;
(
  input  logic [4:0] idx,
  output logic [7:0] data
);

  // Pure table lookup; out-of-range indices read as 0.
  always_comb begin
    data = 8'h00;
    case (idx)
      5'd0:    data = DISPLAY_OFF;
      5'd1:    data = 8'hD5;
      5'd2:    data = 8'h80;
      5'd3:    data = 8'hA8;
      5'd4:    data = 8'h1F;
      5'd5:    data = 8'hD3;
      5'd6:    data = 8'h00;
      5'd7:    data = 8'h40;
      5'd8:    data = 8'h8D;
      5'd9:    data = 8'h14;
      5'd10:   data = 8'h20;
      5'd11:   data = 8'h00;
      5'd12:   data = 8'hA1;
      5'd13:   data = 8'hC8;
      5'd14:   data = 8'hDA;
      5'd15:   data = 8'h02;
      5'd16:   data = 8'h81;
      5'd17:   data = 8'h8F;
      5'd18:   data = 8'hD9;
      5'd19:   data = 8'hF1;
      5'd20:   data = 8'hDB;
      5'd21:   data = 8'h40;
      5'd22:   data = 8'hA4;
      5'd23:   data = 8'hA6;
      5'd24:   data = 8'hAF;
      5'd25:   data = SET_COL;
      5'd26:   data = 8'h00;
      5'd27:   data = 8'h7F;
      5'd28:   data = SET_PAGE;
      5'd29:   data = 8'h00;
      5'd30:   data = 8'h03;
      default: data = 8'h00;
    endcase
  end

endmodule

// File: rtl/oled_refresh_ctrl.sv
// SSD1306 128x32 refresh sequencer driving a shared I2C byte master.
// Sends the init table once, then on request the address window and the
// 512-byte frame buffer; NACKs back off and restart from init.
module oled_refresh_ctrl
  import oled_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR     = 7'h3C,
  parameter int         FB_BYTES     = 512,
  parameter int         RETRY_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_req,
  output logic [8:0] fb_addr,
  input  logic [7:0] fb_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       tx_stop,
  input  logic       tx_ready,
  input  logic       byte_done,
  input  logic       byte_nack,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] err_cnt
);

  localparam logic [7:0] ADDR_BYTE = {I2C_ADDR, 1'b0};
  localparam int CNT_W = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BO_LAST = CNT_W'(RETRY_CYCLES - 1);
  localparam logic [8:0] IDX_LAST = 9'(FB_BYTES - 1);

  state_t           state_r;
  logic [4:0]       pos_r;
  logic [8:0]       idx_r;
  logic [8:0]       fb_addr_r;
  logic [CNT_W-1:0] bo_cnt_r;
  logic             wait_done_r;
  logic             pending_r;
  logic             init_ok_r;
  logic             tx_valid_r;
  logic [7:0]       tx_data_r;
  logic             tx_start_r;
  logic             tx_stop_r;
  logic             busy_r;
  logic             frame_done_r;
  logic [7:0]       err_cnt_r;

  logic [4:0]       rom_idx_s;
  logic [7:0]       rom_data_s;
  logic [7:0]       byte_s;
  logic             start_s;
  logic             stop_s;
  logic             last_s;

  oled_cmd_rom u_rom (
    .idx  (rom_idx_s),
    .data (rom_data_s)
  );

  // Select the byte for the current position; last_s marks the final byte of the state.
  always_comb begin
    rom_idx_s = 5'd0;
    byte_s    = 8'h00;
    start_s   = 1'b0;
    stop_s    = 1'b0;
    last_s    = 1'b0;
    if (state_r == ST_WIN_TX) begin
      rom_idx_s = WIN_BASE + pos_r - 5'd2;
    end else begin
      rom_idx_s = pos_r - 5'd2;
    end
    case (state_r)
      ST_INIT_TX, ST_WIN_TX, ST_DATA_HDR: begin
        if (pos_r == 5'd0) begin
          byte_s  = ADDR_BYTE;
          start_s = 1'b1;
        end else if (pos_r == 5'd1) begin
          byte_s = (state_r == ST_DATA_HDR) ? CTRL_DATA : CTRL_CMD;
        end else begin
          byte_s = rom_data_s;
        end
        if (state_r == ST_INIT_TX) begin
          last_s = (pos_r == INIT_LAST_POS);
          stop_s = last_s;
        end else if (state_r == ST_WIN_TX) begin
          last_s = (pos_r == WIN_LAST_POS);
          stop_s = last_s;
        end else begin
          last_s = (pos_r == HDR_LAST_POS);
          stop_s = 1'b0;
        end
      end
      ST_DATA_TX: begin
        byte_s = fb_data;
        last_s = (idx_r == IDX_LAST);
        stop_s = last_s;
      end
      default: begin
        byte_s = 8'h00;
      end
    endcase
  end

  // Main sequencer: state, byte handshake, request coalescing and NACK recovery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_INIT_PEND;
      pos_r        <= 5'd0;
      idx_r        <= 9'd0;
      fb_addr_r    <= 9'd0;
      bo_cnt_r     <= '0;
      wait_done_r  <= 1'b0;
      pending_r    <= 1'b0;
      init_ok_r    <= 1'b0;
      tx_valid_r   <= 1'b0;
      tx_data_r    <= 8'h00;
      tx_start_r   <= 1'b0;
      tx_stop_r    <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      err_cnt_r    <= 8'h00;
    end else begin
      frame_done_r <= 1'b0;
      // Any request not consumed below is remembered; entering WIN_TX clears it.
      if (frame_req) begin
        pending_r <= 1'b1;
      end
      case (state_r)
        ST_INIT_PEND: begin
          state_r <= ST_INIT_TX;
          pos_r   <= 5'd0;
          busy_r  <= 1'b1;
        end
        ST_IDLE: begin
          if (init_ok_r && (frame_req || pending_r)) begin
            state_r   <= ST_WIN_TX;
            pos_r     <= 5'd0;
            pending_r <= 1'b0;
            busy_r    <= 1'b1;
          end
        end
        ST_DATA_FETCH: begin
          state_r <= ST_DATA_TX;
        end
        ST_BACKOFF: begin
          if (bo_cnt_r == BO_LAST) begin
            state_r  <= ST_INIT_TX;
            pos_r    <= 5'd0;
            bo_cnt_r <= '0;
          end else begin
            bo_cnt_r <= bo_cnt_r + CNT_W'(1);
          end
        end
        ST_INIT_TX, ST_WIN_TX, ST_DATA_HDR, ST_DATA_TX: begin
          if (!tx_valid_r && !wait_done_r) begin
            tx_valid_r <= 1'b1;
            tx_data_r  <= byte_s;
            tx_start_r <= start_s;
            tx_stop_r  <= stop_s;
          end else if (tx_valid_r) begin
            if (tx_ready) begin
              tx_valid_r  <= 1'b0;
              tx_data_r   <= 8'h00;
              tx_start_r  <= 1'b0;
              tx_stop_r   <= 1'b0;
              wait_done_r <= 1'b1;
            end
          end else if (byte_done) begin
            wait_done_r <= 1'b0;
            if (byte_nack) begin
              // Master already sent STOP; drop the frame and rebuild from init.
              err_cnt_r <= sat_inc8(err_cnt_r);
              init_ok_r <= 1'b0;
              pending_r <= 1'b1;
              bo_cnt_r  <= '0;
              state_r   <= ST_BACKOFF;
            end else if (!last_s) begin
              if (state_r == ST_DATA_TX) begin
                idx_r     <= idx_r + 9'd1;
                fb_addr_r <= idx_r + 9'd1;
                state_r   <= ST_DATA_FETCH;
              end else begin
                pos_r <= pos_r + 5'd1;
              end
            end else begin
              case (state_r)
                ST_WIN_TX: begin
                  state_r <= ST_DATA_HDR;
                  pos_r   <= 5'd0;
                end
                ST_DATA_HDR: begin
                  idx_r     <= 9'd0;
                  fb_addr_r <= 9'd0;
                  state_r   <= ST_DATA_FETCH;
                end
                ST_INIT_TX, ST_DATA_TX: begin
                  if (state_r == ST_INIT_TX) begin
                    init_ok_r <= 1'b1;
                  end else begin
                    frame_done_r <= 1'b1;
                  end
                  if (pending_r || frame_req) begin
                    state_r   <= ST_WIN_TX;
                    pos_r     <= 5'd0;
                    pending_r <= 1'b0;
                  end else begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                  end
                end
                default: begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                end
              endcase
            end
          end
        end
        default: begin
          state_r <= ST_INIT_PEND;
        end
      endcase
    end
  end

  assign fb_addr    = fb_addr_r;
  assign tx_valid   = tx_valid_r;
  assign tx_data    = tx_data_r;
  assign tx_start   = tx_start_r;
  assign tx_stop    = tx_stop_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign err_cnt    = err_cnt_r;

endmodule
